// File: rtl/axi_rd_addr_arbiter.sv
// Round-robin arbiter that shares one AXI read-address master port between NUM_REQ
// requesters and tracks issued-but-incomplete bursts.
module axi_rd_addr_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_MAX_WIDTH    = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*4-1:0]          req_len,
   input  logic                          rd_done,
   output logic                          arvalid,
   input  logic                          arready,
   output logic [ID_MAX_WIDTH-1:0]       arid,
   output logic [ADDR_WIDTH-1:0]         araddr,
   output logic [3:0]                    arlen,
   output logic [2:0]                    arsize,
   output logic [1:0]                    arbrust,
   output logic [1:0]                    arlock,
   output logic [3:0]                    arcache,
   output logic [2:0]                    arprot,
   output logic [3:0]                    arqos,
   output logic [3:0]                    arregion,
   output logic [7:0]                    outstanding,
   output logic                          err_underflow
);

   localparam int         PTR_W   = $clog2(NUM_REQ);
   localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [PTR_W-1:0]        ptr_r;
   logic [PTR_W-1:0]        idx_s;
   logic [PTR_W-1:0]        grant_idx_s;
   logic                    grant_found_s;
   logic                    grant_s;
   logic                    handshake_s;
   logic                    arvalid_r;
   logic [ID_MAX_WIDTH-1:0] arid_r;
   logic [ADDR_WIDTH-1:0]   araddr_r;
   logic [3:0]              arlen_r;
   logic [7:0]              outstanding_r;
   logic                    err_underflow_r;

   assign handshake_s = arvalid_r & arready;

   // Round-robin search: walk from farthest to nearest so the slot right after ptr wins.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      idx_s         = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx_s         = PTR_W'((int'(ptr_r) + k) % NUM_REQ);
         grant_found_s = grant_found_s | req_valid[idx_s];
         grant_idx_s   = req_valid[idx_s] ? idx_s : grant_idx_s;
      end
   end

   // Next-state and acceptance decode.
   always_comb begin
      state_nxt_s = state_r;
      req_ready   = '0;
      grant_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (grant_found_s && (outstanding_r < MAX_OUT)) begin
               grant_s                = 1'b1;
               req_ready[grant_idx_s] = 1'b1;
               state_nxt_s            = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (handshake_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // AR channel registers; fields are frozen from grant until the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         arvalid_r <= 1'b0;
         arid_r    <= '0;
         araddr_r  <= '0;
         arlen_r   <= 4'd0;
         ptr_r     <= PTR_W'(NUM_REQ - 1);
      end else if (grant_s) begin
         arvalid_r <= 1'b1;
         arid_r    <= ID_MAX_WIDTH'(grant_idx_s);
         araddr_r  <= req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
         arlen_r   <= req_len[grant_idx_s*4 +: 4];
         ptr_r     <= grant_idx_s;
      end else if (handshake_s) begin
         arvalid_r <= 1'b0;
      end
   end

   // Outstanding burst counter; a completion with nothing in flight is flagged, not wrapped.
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_r   <= 8'd0;
         err_underflow_r <= 1'b0;
      end else begin
         case ({handshake_s, rd_done})
            2'b10: outstanding_r <= outstanding_r + 8'd1;
            2'b01: begin
               if (outstanding_r == 8'd0) begin
                  err_underflow_r <= 1'b1;
               end else begin
                  outstanding_r <= outstanding_r - 8'd1;
               end
            end
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   assign arvalid       = arvalid_r;
   assign arid          = arid_r;
   assign araddr        = araddr_r;
   assign arlen         = arlen_r;
   assign arsize        = 3'($clog2(DATA_WIDTH / 8));
   assign arbrust       = 2'b01;
   assign arlock        = 2'b00;
   assign arcache       = 4'b0011;
   assign arprot        = 3'b000;
   assign arqos         = 4'b0000;
   assign arregion      = 4'b0000;
   assign outstanding   = outstanding_r;
   assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_axi_rd_addr_arbiter.sv
// Randomized scoreboard bench: a transaction-level model predicts grants and AR contents;
// a separate monitor checks every presented AR against the expected queue.
module tb_axi_rd_addr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int MO = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*4-1:0]  req_len;
   logic            rd_done;
   logic            arvalid;
   logic            arready;
   logic [3:0]      arid;
   logic [AW-1:0]   araddr;
   logic [3:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arbrust;
   logic [1:0]      arlock;
   logic [3:0]      arcache;
   logic [2:0]      arprot;
   logic [3:0]      arqos;
   logic [3:0]      arregion;
   logic [7:0]      outstanding;
   logic            err_underflow;

   axi_rd_addr_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .ID_MAX_WIDTH(4), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len), .rd_done(rd_done),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arbrust(arbrust), .arlock(arlock), .arcache(arcache),
      .arprot(arprot), .arqos(arqos), .arregion(arregion),
      .outstanding(outstanding), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] addr;
      logic [3:0]  len;
   } ar_t;

   ar_t         sbq[$];
   int          checks = 0;
   int          errors = 0;

   // Reference model: who is waiting, who was served last, what is in flight.
   bit          act[N];
   logic [31:0] cur_addr[N];
   logic [3:0]  cur_len[N];
   bit          m_busy;
   int          m_out;
   bit          m_err;
   int          m_last;

   function automatic void chk(string name, logic [63:0] actual, logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endfunction

   function automatic void model_reset();
      m_busy = 1'b0;
      m_out  = 0;
      m_err  = 1'b0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) act[i] = 1'b0;
      sbq.delete();
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = act[i];
         req_addr[i*AW +: AW]  = cur_addr[i];
         req_len[i*4 +: 4]     = cur_len[i];
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      arready   = 1'b0;
      rd_done   = 1'b0;
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive_reqs();
      chk("rst_arvalid", 64'(arvalid), 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_err", 64'(err_underflow), 64'd0);
      chk("rst_arid", 64'(arid), 64'd0);
      chk("rst_araddr", 64'(araddr), 64'd0);
      chk("rst_arlen", 64'(arlen), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
   endtask

   // One clock of stimulus plus model prediction; percentages steer the traffic mix.
   task automatic cycle(int p_act, int p_rdy, int p_done, bit under);
      int           g;
      int           i;
      bit           hs;
      logic [N-1:0] exp_ready;
      @(posedge clk);
      #1;
      chk("arvalid", 64'(arvalid), 64'(m_busy));
      chk("outstanding", 64'(outstanding), 64'(m_out));
      chk("err_underflow", 64'(err_underflow), 64'(m_err));
      for (int r = 0; r < N; r++) begin
         if (!act[r] && ($urandom_range(99) < p_act)) begin
            act[r]      = 1'b1;
            cur_addr[r] = $urandom & 32'hFFFF_FFFC;
            cur_len[r]  = 4'($urandom_range(15));
         end else if (act[r] && p_act > 0 && p_act < 100 && $urandom_range(99) < 4) begin
            act[r] = 1'b0;
         end
      end
      drive_reqs();
      arready = ($urandom_range(99) < p_rdy);
      rd_done = ($urandom_range(99) < p_done) && (under || m_out > 0);
      #1;
      g = -1;
      if (!m_busy && m_out < MO) begin
         for (int k = 1; k <= N; k++) begin
            i = (m_last + k) % N;
            if (g < 0 && act[i]) g = i;
         end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      if (g >= 0) begin
         sbq.push_back('{id: g, addr: cur_addr[g], len: cur_len[g]});
         act[g] = 1'b0;
      end
      hs = m_busy && arready;
      if (hs && !rd_done) begin
         m_out++;
      end else if (!hs && rd_done) begin
         if (m_out == 0) m_err = 1'b1;
         else m_out--;
      end
      if (hs) m_busy = 1'b0;
      if (g >= 0) begin
         m_busy = 1'b1;
         m_last = g;
      end
   endtask

   // Monitor: whenever an AR is presented it must match the oldest expected grant.
   always @(posedge clk) begin
      #3;
      if (!rst && arvalid) begin
         if (sbq.size() == 0) begin
            chk("ar_unexpected", 64'd1, 64'd0);
         end else begin
            chk("arid", 64'(arid), 64'(sbq[0].id));
            chk("araddr", 64'(araddr), 64'(sbq[0].addr));
            chk("arlen", 64'(arlen), 64'(sbq[0].len));
            if (arready) void'(sbq.pop_front());
         end
      end
   end

   initial begin
      rst       = 1'b1;
      arready   = 1'b0;
      rd_done   = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_len   = '0;
      for (int i = 0; i < N; i++) begin
         cur_addr[i] = 32'd0;
         cur_len[i]  = 4'd0;
      end
      repeat (2) @(posedge clk);
      do_reset();

      chk("arsize", 64'(arsize), 64'd2);
      chk("arbrust", 64'(arbrust), 64'd1);
      chk("arlock", 64'(arlock), 64'd0);
      chk("arcache", 64'(arcache), 64'd3);
      chk("arprot", 64'(arprot), 64'd0);
      chk("arqos", 64'(arqos), 64'd0);
      chk("arregion", 64'(arregion), 64'd0);

      // Single requester 2, address 0x1000, len 3.
      act[2]      = 1'b1;
      cur_addr[2] = 32'h0000_1000;
      cur_len[2]  = 4'd3;
      repeat (4) cycle(0, 100, 0, 1'b0);
      chk("t1_outstanding", 64'(outstanding), 64'd1);

      // All requesters busy, completions keep pace: rotation 0,1,2,3,0...
      repeat (12) cycle(100, 100, 100, 1'b0);

      // AR stalled by arready low.
      repeat (7) cycle(100, 0, 0, 1'b0);
      cycle(100, 100, 0, 1'b0);

      // Reach the outstanding cap, then release one slot.
      repeat (10) cycle(100, 100, 0, 1'b0);
      cycle(0, 100, 100, 1'b0);
      repeat (4) cycle(100, 100, 0, 1'b0);

      repeat (600) cycle(40, 60, 25, 1'b0);

      // Reset while an AR is stalled; next grant must restart at requester 0.
      repeat (3) cycle(100, 0, 0, 1'b0);
      do_reset();
      repeat (8) cycle(100, 100, 50, 1'b0);

      // Drain, then completion with nothing in flight.
      repeat (24) cycle(0, 100, 100, 1'b0);
      chk("sb_empty", 64'(sbq.size()), 64'd0);
      repeat (3) cycle(0, 100, 100, 1'b1);
      repeat (3) cycle(0, 100, 0, 1'b0);
      chk("underflow_sticky", 64'(err_underflow), 64'd1);
      chk("underflow_count", 64'(outstanding), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
